// File: rtl/booth_arbiter.sv
// -----------------------------------------------------------------------------
// booth_arbiter
// Shares one interrupt-driven booth multiplier among N_REQ requesters. A
// round-robin choice is made in IDLE. The winner's operands are latched and
// the multiplier is started. The arbiter then waits for mul_irq, guarded by a
// watchdog. It acknowledges the interrupt, waits for the multiplier to go
// quiet, and then pulses done/err to the winner.
//
// Ports
//   clk            : single clock, rising edge
//   resetn         : synchronous active-low reset
//   req            : per-requester request level, held until its done pulse
//   op_a, op_b     : packed signed 16-bit operands, requester i in [16i+15:16i]
//   done           : one-cycle pulse to the served requester (one-hot or zero)
//   res            : signed 32-bit product, updated only with a done pulse
//   err            : pulses with done when the operation timed out (res = 0)
//   mul_start      : start to multiplier (high through START, WAIT, ACK)
//   mul_ack        : one-cycle interrupt acknowledge to multiplier
//   mul_a, mul_b   : latched operands to multiplier
//   mul_irq_enable : always 1 (the arbiter only uses interrupt mode)
//   mul_busy, mul_irq, mul_result : status and result from multiplier
// -----------------------------------------------------------------------------
module booth_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  op_a,
    input  logic [16*N_REQ-1:0]  op_b,
    output logic [N_REQ-1:0]     done,
    output logic [31:0]          res,
    output logic [N_REQ-1:0]     err,
    output logic                 mul_start,
    output logic                 mul_ack,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    output logic                 mul_irq_enable,
    input  logic                 mul_busy,
    input  logic                 mul_irq,
    input  logic [31:0]          mul_result
);

    localparam int GW  = 2;                      // grant index width for 4 requesters
    localparam int WDW = $clog2(TIMEOUT + 1);    // watchdog must be able to hold TIMEOUT

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_ACK     = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]       r_state;
    logic [GW-1:0]    r_grant;
    logic [GW-1:0]    r_last;
    logic [WDW-1:0]   r_wd;
    logic             r_timeout;
    logic [31:0]      r_prod;
    logic [N_REQ-1:0] r_done;
    logic [N_REQ-1:0] r_err;
    logic [31:0]      r_res;
    logic             r_mul_start;
    logic             r_mul_ack;
    logic [15:0]      r_mul_a;
    logic [15:0]      r_mul_b;
    logic             r_irq_en;

    logic             w_any;
    logic [GW-1:0]    w_win;
    logic [GW-1:0]    w_idx;

    // Round-robin pick: scan from last_grant+1 upward with wrap, first requester wins
    always_comb begin
        w_any = 1'b0;
        w_win = r_last;
        w_idx = r_last;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = GW'((int'(r_last) + k) % N_REQ);
            if (!w_any && req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end else begin
                w_win = w_win;
            end
        end
    end

    // Arbiter FSM, multiplier handshake, watchdog and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_grant     <= {GW{1'b0}};
            r_last      <= GW'(N_REQ - 1);       // requester 0 is searched first
            r_wd        <= {WDW{1'b0}};
            r_timeout   <= 1'b0;
            r_prod      <= 32'd0;
            r_done      <= {N_REQ{1'b0}};
            r_err       <= {N_REQ{1'b0}};
            r_res       <= 32'd0;
            r_mul_start <= 1'b0;
            r_mul_ack   <= 1'b0;
            r_mul_a     <= 16'd0;
            r_mul_b     <= 16'd0;
            r_irq_en    <= 1'b1;
        end else begin
            r_irq_en <= 1'b1;
            // done/err are single-cycle pulses; only the RELEASE exit raises them
            r_done   <= {N_REQ{1'b0}};
            r_err    <= {N_REQ{1'b0}};
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant     <= w_win;
                        r_last      <= w_win;
                        r_mul_a     <= op_a[{w_win, 4'b0000} +: 16];
                        r_mul_b     <= op_b[{w_win, 4'b0000} +: 16];
                        r_mul_start <= 1'b1;
                        r_state     <= S_START;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_START: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // An interrupt in the last watchdog cycle still wins over the timeout
                    if (mul_irq) begin
                        r_mul_ack <= 1'b1;
                        r_state   <= S_ACK;
                    end else if (r_wd == WDW'(TIMEOUT - 1)) begin
                        r_wd        <= r_wd + 1'b1;
                        r_timeout   <= 1'b1;
                        r_mul_start <= 1'b0;
                        r_state     <= S_RELEASE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_ACK: begin
                    // Product is held internally so res only changes together with done
                    r_prod      <= mul_result;
                    r_mul_ack   <= 1'b0;
                    r_mul_start <= 1'b0;
                    r_state     <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!mul_busy && !mul_irq) begin
                        r_done[r_grant] <= 1'b1;
                        r_err[r_grant]  <= r_timeout;
                        r_res           <= r_timeout ? 32'd0 : r_prod;
                        r_state         <= S_DONE;
                    end else begin
                        r_state <= S_RELEASE;
                    end
                end
                S_DONE: begin
                    r_timeout <= 1'b0;
                    r_wd      <= {WDW{1'b0}};
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_mul_start <= 1'b0;
                    r_mul_ack   <= 1'b0;
                end
            endcase
        end
    end

    assign done           = r_done;
    assign err            = r_err;
    assign res            = r_res;
    assign mul_start      = r_mul_start;
    assign mul_ack        = r_mul_ack;
    assign mul_a          = r_mul_a;
    assign mul_b          = r_mul_b;
    assign mul_irq_enable = r_irq_en;

endmodule

// File: tb/tb_booth_arbiter.sv
module tb_booth_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req;
    logic [63:0] op_a, op_b;
    logic [3:0]  done, err;
    logic [31:0] res;
    logic        mul_start, mul_ack, mul_irq_enable;
    logic [15:0] mul_a, mul_b;
    logic        mul_busy, mul_irq;
    logic [31:0] mul_result;

    booth_arbiter #(.N_REQ(4), .TIMEOUT(64)) dut (
        .clk(clk), .resetn(resetn), .req(req), .op_a(op_a), .op_b(op_b),
        .done(done), .res(res), .err(err),
        .mul_start(mul_start), .mul_ack(mul_ack), .mul_a(mul_a), .mul_b(mul_b),
        .mul_irq_enable(mul_irq_enable), .mul_busy(mul_busy), .mul_irq(mul_irq),
        .mul_result(mul_result)
    );

    always #5 clk = ~clk;

    // Multiplier model: arms on mul_start, raises irq after m_lat cycles, clears on ack
    logic       m_armed, no_irq;
    int         m_cnt;
    int         m_lat = 2;
    always @(posedge clk) begin
        if (!resetn || !mul_start) begin
            mul_busy <= 1'b0; mul_irq <= 1'b0; m_armed <= 1'b0;
        end else if (mul_ack) begin
            mul_busy <= 1'b0; mul_irq <= 1'b0;
        end else if (!m_armed) begin
            m_armed <= 1'b1; mul_busy <= 1'b1; m_cnt <= m_lat;
            mul_result <= 32'hDEAD_BEEF;
        end else if (mul_busy && !mul_irq && !no_irq) begin
            if (m_cnt == 0) begin
                mul_irq    <= 1'b1;
                mul_result <= $signed(mul_a) * $signed(mul_b);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct { int idx; logic [31:0] r; logic e; } exp_t;
    exp_t q[$];

    task automatic push(input int idx, input int r, input logic e);
        exp_t x;
        x.idx = idx; x.r = r; x.e = e;
        q.push_back(x);
    endtask

    // Scoreboard monitor plus handshake counters, sampled on the falling edge
    int   start_rises = 0, start_hi = 0, ack_hi = 0;
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (mul_start && !prev_start) start_rises++;
        if (mul_start) start_hi++;
        if (mul_ack) ack_hi++;
        prev_start = mul_start;
        if (done !== 4'b0000) begin
            check("done_onehot", {31'd0, $onehot(done)}, 32'd1);
            if (q.size() == 0) begin
                check("unexpected_done", {28'd0, done}, 32'd0);
            end else begin
                e = q.pop_front();
                check("done_bit", {28'd0, done}, 32'd1 << e.idx);
                check("res", res, e.r);
                check("err", {28'd0, err}, {31'd0, e.e} << e.idx);
            end
        end
    end

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        op_a[16*i +: 16] = a;
        op_b[16*i +: 16] = b;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req = 4'b0000;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Waits (bounded) for n done pulses, dropping each served request
    task automatic wait_dones(input int n, input string tag);
        int got = 0;
        for (int c = 0; c < 400 && got < n; c++) begin
            @(negedge clk);
            if (done != 4'b0000) begin
                got++;
                req = req & ~done;
            end
        end
        check({tag, "_done_count"}, 32'(got), 32'(n));
    endtask

    initial begin
        resetn = 1'b0; req = 4'b0000; op_a = 64'd0; op_b = 64'd0; no_irq = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_done", {28'd0, done}, 32'd0);
        check("rst_err", {28'd0, err}, 32'd0);
        check("rst_res", res, 32'd0);
        check("rst_start", {31'd0, mul_start}, 32'd0);
        check("rst_ack", {31'd0, mul_ack}, 32'd0);
        check("rst_ab", {mul_a, mul_b}, 32'd0);
        check("rst_irq_en", {31'd0, mul_irq_enable}, 32'd1);
        resetn = 1'b1;
        @(negedge clk);

        // Single request: 2*16
        start_rises = 0; ack_hi = 0;
        set_op(0, 16'd2, 16'd16);
        push(0, 32, 1'b0);
        req = 4'b0001;
        @(negedge clk);
        check("lat_start", {31'd0, mul_start}, 32'd1);
        check("lat_ab", {mul_a, mul_b}, {16'd2, 16'd16});
        wait_dones(1, "single");
        repeat (3) @(negedge clk);
        check("res_hold", res, 32'd32);
        check("single_start_rises", 32'(start_rises), 32'd1);
        check("single_ack_cycles", 32'(ack_hi), 32'd1);

        // Four requesters from reset: order 0,1,2,3
        do_reset();
        set_op(0, 16'hFFF8, 16'hFF84);   // -8 * -124
        set_op(1, 16'd150, 16'hFFDA);    // 150 * -38
        set_op(2, 16'hFD62, 16'd2);      // -670 * 2
        set_op(3, 16'hFFFF, 16'hFFFF);   // -1 * -1
        push(0, 992, 1'b0); push(1, -5700, 1'b0); push(2, -1340, 1'b0); push(3, 1, 1'b0);
        req = 4'b1111;
        wait_dones(4, "rr4");

        // Requester 0 re-asserts right after done while 2 is pending: 2 goes first
        set_op(0, 16'h7FFF, 16'h7FFF);
        set_op(2, 16'h8000, 16'h8000);
        push(0, 1073676289, 1'b0); push(2, 1073741824, 1'b0); push(0, 1073676289, 1'b0);
        req = 4'b0001;
        repeat (3) @(negedge clk);
        req[2] = 1'b1;
        wait_dones(1, "reassert_first");
        req[0] = 1'b1;
        wait_dones(2, "reassert_rest");

        // Multiplier never interrupts: watchdog timeout
        no_irq = 1'b1;
        set_op(1, 16'd5, 16'd5);
        start_hi = 0; ack_hi = 0;
        push(1, 0, 1'b1);
        req = 4'b0010;
        wait_dones(1, "timeout");
        check("timeout_start_cycles", 32'(start_hi), 32'd65);
        check("timeout_no_ack", 32'(ack_hi), 32'd0);
        @(negedge clk);
        check("timeout_idle_start", {31'd0, mul_start}, 32'd0);

        // Reset while waiting: no done, all outputs back to reset values
        req = 4'b0001;
        repeat (10) @(negedge clk);
        check("midrst_in_wait", {31'd0, mul_start}, 32'd1);
        resetn = 1'b0; req = 4'b0000;
        @(negedge clk);
        check("midrst_done", {28'd0, done}, 32'd0);
        check("midrst_res", res, 32'd0);
        check("midrst_start_ack", {30'd0, mul_start, mul_ack}, 32'd0);
        check("midrst_ab", {mul_a, mul_b}, 32'd0);
        resetn = 1'b1; no_irq = 1'b0;
        set_op(2, 16'd7, 16'hFFF7);      // 7 * -9
        push(2, -63, 1'b0);
        req = 4'b0100;
        wait_dones(1, "after_rst");

        // Requester 0 drops its request one cycle after grant
        set_op(0, 16'd123, 16'hFFD3);    // 123 * -45
        push(0, -5535, 1'b0);
        req = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        req = 4'b0000;
        wait_dones(1, "drop_req");

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
